// File: rtl/node2noc_admission_ctrl_pkg.sv
// rtl/node2noc_admission_ctrl_pkg.sv - shared head-field widths, table depth and request FSM encoding
package node2noc_admission_ctrl_pkg;

    // Head-flit field widths and pending-table depth shared across the NIC
    localparam int TABLE_PENDING_NODE2NOC_WIDTH = 8;
    localparam int N_BIT_SRC_HEAD_FLIT          = 4;
    localparam int N_BIT_DEST_HEAD_FLIT         = 4;
    localparam int N_BIT_CMD_HEAD_FLIT          = 3;
    localparam int ORPHAN_CNT_W                 = 8;

    // Request FSM: IDLE accepts a new request, HOLD presents it to the packetizer
    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_HOLD = 1'b1
    } req_state_e;

endpackage

// File: rtl/node2noc_rsp_checker.sv
// rtl/node2noc_rsp_checker.sv - reply hit/orphan pulses and saturating orphan counter
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   rsp_valid_i       reply head flit valid
//   is_pending_i      pending-table hit for the current reply (combinational)
//   rsp_hit_o         one-cycle registered pulse: reply matched a pending entry
//   rsp_orphan_o      one-cycle registered pulse: reply matched nothing
//   orphan_cnt_o      count of unmatched replies, saturates at all-ones
module node2noc_rsp_checker
    import node2noc_admission_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rsp_valid_i,
    input  logic                    is_pending_i,
    output logic                    rsp_hit_o,
    output logic                    rsp_orphan_o,
    output logic [ORPHAN_CNT_W-1:0] orphan_cnt_o
);

    localparam logic [ORPHAN_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ORPHAN_CNT_W-1:0] CNT_ONE = ORPHAN_CNT_W'(1);

    logic                    rsp_hit_d,    rsp_hit_q;
    logic                    rsp_orphan_d, rsp_orphan_q;
    logic [ORPHAN_CNT_W-1:0] orphan_cnt_d, orphan_cnt_q;

    always_comb begin
        rsp_hit_d    = rsp_valid_i & is_pending_i;
        rsp_orphan_d = rsp_valid_i & ~is_pending_i;
        orphan_cnt_d = orphan_cnt_q;
        if (rsp_orphan_d && (orphan_cnt_q != CNT_MAX)) begin
            orphan_cnt_d = orphan_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_hit_q    <= 1'b0;
            rsp_orphan_q <= 1'b0;
            orphan_cnt_q <= '0;
        end else begin
            rsp_hit_q    <= rsp_hit_d;
            rsp_orphan_q <= rsp_orphan_d;
            orphan_cnt_q <= orphan_cnt_d;
        end
    end

    assign rsp_hit_o    = rsp_hit_q;
    assign rsp_orphan_o = rsp_orphan_q;
    assign orphan_cnt_o = orphan_cnt_q;

endmodule

// File: rtl/node2noc_admission_ctrl.sv
// rtl/node2noc_admission_ctrl.sv - admits master requests into the NoC against pending-table capacity
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      master request handshake
//   req_sender_i/recipient_i/cmd_i requested head fields
//   pkt_valid_o / pkt_ready_i      head info handshake towards the packetizer
//   pkt_sender_o/recipient_o/cmd_o held head info
//   new_pending_transaction_o      pending-table insert strobe, with new_* fields
//   rsp_valid_i, rsp_src/dest/cmd_i reply head flit from the NoC
//   query_o, delete_transaction_o  pending-table query/delete strobes, with query_* fields
//   is_a_pending_transaction_i     pending-table hit for the query
//   rsp_hit_o, rsp_orphan_o        registered reply-status pulses
//   occupancy_o                    reserved pending-table slots
//   orphan_cnt_o                   saturating unmatched-reply count
module node2noc_admission_ctrl
    import node2noc_admission_ctrl_pkg::*;
#(
    parameter int DEPTH      = TABLE_PENDING_NODE2NOC_WIDTH,
    parameter int N_BITS_CNT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [N_BIT_SRC_HEAD_FLIT-1:0]  req_sender_i,
    input  logic [N_BIT_DEST_HEAD_FLIT-1:0] req_recipient_i,
    input  logic [N_BIT_CMD_HEAD_FLIT-1:0]  req_cmd_i,
    output logic                            pkt_valid_o,
    input  logic                            pkt_ready_i,
    output logic [N_BIT_SRC_HEAD_FLIT-1:0]  pkt_sender_o,
    output logic [N_BIT_DEST_HEAD_FLIT-1:0] pkt_recipient_o,
    output logic [N_BIT_CMD_HEAD_FLIT-1:0]  pkt_cmd_o,
    output logic                            new_pending_transaction_o,
    output logic [N_BIT_SRC_HEAD_FLIT-1:0]  new_sender_o,
    output logic [N_BIT_DEST_HEAD_FLIT-1:0] new_recipient_o,
    output logic [N_BIT_CMD_HEAD_FLIT-1:0]  new_transaction_type_o,
    input  logic                            rsp_valid_i,
    input  logic [N_BIT_SRC_HEAD_FLIT-1:0]  rsp_src_i,
    input  logic [N_BIT_DEST_HEAD_FLIT-1:0] rsp_dest_i,
    input  logic [N_BIT_CMD_HEAD_FLIT-1:0]  rsp_cmd_i,
    output logic                            query_o,
    output logic                            delete_transaction_o,
    output logic [N_BIT_SRC_HEAD_FLIT-1:0]  query_sender_o,
    output logic [N_BIT_DEST_HEAD_FLIT-1:0] query_recipient_o,
    output logic [N_BIT_CMD_HEAD_FLIT-1:0]  query_transaction_type_o,
    input  logic                            is_a_pending_transaction_i,
    output logic                            rsp_hit_o,
    output logic                            rsp_orphan_o,
    output logic [N_BITS_CNT-1:0]           occupancy_o,
    output logic [ORPHAN_CNT_W-1:0]         orphan_cnt_o
);

    localparam logic [N_BITS_CNT-1:0] DEPTH_C = N_BITS_CNT'(DEPTH);
    localparam logic [N_BITS_CNT-1:0] CNT_ONE = N_BITS_CNT'(1);

    req_state_e                      state_d, state_q;
    logic [N_BIT_SRC_HEAD_FLIT-1:0]  pkt_sender_d, pkt_sender_q;
    logic [N_BIT_DEST_HEAD_FLIT-1:0] pkt_recipient_d, pkt_recipient_q;
    logic [N_BIT_CMD_HEAD_FLIT-1:0]  pkt_cmd_d, pkt_cmd_q;
    logic [N_BITS_CNT-1:0]           occupancy_d, occupancy_q;

    logic accept;
    logic insert;
    logic rsp_hit_now;
    logic release_slot;

    // Request FSM and held head fields
    always_comb begin
        state_d         = state_q;
        pkt_sender_d    = pkt_sender_q;
        pkt_recipient_d = pkt_recipient_q;
        pkt_cmd_d       = pkt_cmd_q;
        req_ready_o     = 1'b0;
        pkt_valid_o     = 1'b0;
        accept          = 1'b0;
        insert          = 1'b0;

        unique case (state_q)
            REQ_IDLE: begin
                req_ready_o = (occupancy_q < DEPTH_C);
                accept      = req_valid_i & req_ready_o;
                if (accept) begin
                    pkt_sender_d    = req_sender_i;
                    pkt_recipient_d = req_recipient_i;
                    pkt_cmd_d       = req_cmd_i;
                    state_d         = REQ_HOLD;
                end
            end
            REQ_HOLD: begin
                pkt_valid_o = 1'b1;
                insert      = pkt_ready_i;
                if (insert) begin
                    state_d = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    // Slot is reserved at accept time, so the insert cycle never touches occupancy.
    // A hit with nothing reserved is ignored to avoid underflow.
    always_comb begin
        rsp_hit_now  = rsp_valid_i & is_a_pending_transaction_i;
        release_slot = rsp_hit_now & (occupancy_q != '0);
        occupancy_d  = occupancy_q;
        if (accept && !release_slot) begin
            occupancy_d = occupancy_q + CNT_ONE;
        end else if (release_slot && !accept) begin
            occupancy_d = occupancy_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= REQ_IDLE;
            pkt_sender_q    <= '0;
            pkt_recipient_q <= '0;
            pkt_cmd_q       <= '0;
            occupancy_q     <= '0;
        end else begin
            state_q         <= state_d;
            pkt_sender_q    <= pkt_sender_d;
            pkt_recipient_q <= pkt_recipient_d;
            pkt_cmd_q       <= pkt_cmd_d;
            occupancy_q     <= occupancy_d;
        end
    end

    assign pkt_sender_o              = pkt_sender_q;
    assign pkt_recipient_o           = pkt_recipient_q;
    assign pkt_cmd_o                 = pkt_cmd_q;
    assign new_pending_transaction_o = insert;
    assign new_sender_o              = pkt_sender_q;
    assign new_recipient_o           = pkt_recipient_q;
    assign new_transaction_type_o    = pkt_cmd_q;
    assign occupancy_o               = occupancy_q;

    // Replies travel back with source and destination swapped relative to the
    // original request, so the table key is rebuilt from the reversed fields.
    assign query_o                  = rsp_valid_i;
    assign delete_transaction_o     = rsp_valid_i;
    assign query_sender_o           = rsp_dest_i;
    assign query_recipient_o        = rsp_src_i;
    assign query_transaction_type_o = rsp_cmd_i;

    node2noc_rsp_checker u_rsp_checker (
        .clk          (clk),
        .rst          (rst),
        .rsp_valid_i  (rsp_valid_i),
        .is_pending_i (is_a_pending_transaction_i),
        .rsp_hit_o    (rsp_hit_o),
        .rsp_orphan_o (rsp_orphan_o),
        .orphan_cnt_o (orphan_cnt_o)
    );

endmodule
